// File: rtl/mips_hazard_pkg.sv
// ---------------------------------------------------------------------------
// mips_hazard_pkg
// Shared types and constants for the hazard/forwarding unit.
//   fwd_sel_e  : EX-stage operand source select (RF / WB / MEM)
//   hz_state_e : stall sequencer state (RUN / STALL)
//   ZERO_REG   : architectural zero register, never a forwarding source
// ---------------------------------------------------------------------------
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Per-operand address comparison for one source channel.
// Ports:
//   ex_src_i        EX-stage source register of this channel
//   id_src_i        ID-stage source register of this channel
//   ex_write_reg_i  EX destination register
//   mem_reg_write_i / mem_mem_read_i / mem_write_reg_i  MEM-stage writer info
//   wb_reg_write_i  / wb_write_reg_i                    WB-stage writer info
//   fwd_e_o         EX operand select (MEM beats WB, else RF)
//   fwd_d_o         ID branch-compare select, 1 = take MEM ALU result
//   id_ex_hit_o     ID source equals EX destination (non-zero)
//   id_mem_hit_o    ID source equals MEM destination (non-zero)
// Purely combinational.
// ---------------------------------------------------------------------------
module fwd_match
  import mips_hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] ex_src_i,
  input  logic [ADDR_W-1:0] id_src_i,
  input  logic [ADDR_W-1:0] ex_write_reg_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [ADDR_W-1:0] mem_write_reg_i,
  input  logic              wb_reg_write_i,
  input  logic [ADDR_W-1:0] wb_write_reg_i,
  output fwd_sel_e          fwd_e_o,
  output logic              fwd_d_o,
  output logic              id_ex_hit_o,
  output logic              id_mem_hit_o
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic ex_live;
  logic id_live;

  // r0 is hard-wired, so a zero source never depends on an in-flight write.
  assign ex_live = (ex_src_i != ZERO);
  assign id_live = (id_src_i != ZERO);

  always_comb begin
    fwd_e_o = FWD_RF;
    if (ex_live && mem_reg_write_i && (mem_write_reg_i == ex_src_i)) begin
      fwd_e_o = FWD_MEM;
    end else if (ex_live && wb_reg_write_i && (wb_write_reg_i == ex_src_i)) begin
      fwd_e_o = FWD_WB;
    end
  end

  // A load in MEM has no data yet for the ID comparator; that case is a
  // branch hazard handled by the stall logic instead.
  assign fwd_d_o      = id_live && mem_reg_write_i && !mem_mem_read_i &&
                        (mem_write_reg_i == id_src_i);
  assign id_ex_hit_o  = id_live && (ex_write_reg_i == id_src_i);
  assign id_mem_hit_o = id_live && (mem_write_reg_i == id_src_i);

endmodule

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
// Forwarding selects and stall/flush control for a 5-stage MIPS pipeline.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   idSrc, idBranch               ID source registers / branch flag
//   exSrc, exRegWrite, exMemRead, exWriteReg   EX-stage instruction info
//   MEMregWrite, MEMmemRead, MEMwriteReg        MEM-stage instruction info
//   WBregWrite, WBwriteReg                      WB-stage instruction info
//   forwardE   per-channel EX select [2i+1:2i]: 00 RF, 01 WB, 10 MEM
//   forwardD   per-channel ID branch-compare select, 1 = MEM
//   stallF, stallD, flushE        hold PC, hold IF/ID, bubble into ID/EX
//   stallCount saturating count of stall cycles
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stallCount is a saturating counter
//   undefined -> no counter flops, stallCount reads 0
// ---------------------------------------------------------------------------
module hazard_forward_unit
  import mips_hazard_pkg::*;
#(
  parameter int ADDR_W          = 5,
  parameter int NUM_SRC         = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] idSrc,
  input  logic                      idBranch,
  input  logic [NUM_SRC*ADDR_W-1:0] exSrc,
  input  logic                      exRegWrite,
  input  logic                      exMemRead,
  input  logic [ADDR_W-1:0]         exWriteReg,
  input  logic                      MEMregWrite,
  input  logic                      MEMmemRead,
  input  logic [ADDR_W-1:0]         MEMwriteReg,
  input  logic                      WBregWrite,
  input  logic [ADDR_W-1:0]         WBwriteReg,
  output logic [2*NUM_SRC-1:0]      forwardE,
  output logic [NUM_SRC-1:0]        forwardD,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      flushE,
  output logic [CNT_W-1:0]          stallCount
);

  // The first bubble comes from the combinational hazard itself; the FSM
  // only supplies the remaining LOAD_USE_CYCLES-1.
  localparam logic [3:0] REM_INIT = 4'(LOAD_USE_CYCLES - 1);

  logic [NUM_SRC-1:0] id_ex_hit;
  logic [NUM_SRC-1:0] id_mem_hit;
  logic               lu_haz;
  logic               br_haz;
  logic               stall;

  hz_state_e  state_q, state_d;
  logic [3:0] rem_q, rem_d;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ch
    fwd_sel_e sel;

    fwd_match #(
      .ADDR_W (ADDR_W)
    ) u_fwd_match (
      .ex_src_i        (exSrc[gi*ADDR_W +: ADDR_W]),
      .id_src_i        (idSrc[gi*ADDR_W +: ADDR_W]),
      .ex_write_reg_i  (exWriteReg),
      .mem_reg_write_i (MEMregWrite),
      .mem_mem_read_i  (MEMmemRead),
      .mem_write_reg_i (MEMwriteReg),
      .wb_reg_write_i  (WBregWrite),
      .wb_write_reg_i  (WBwriteReg),
      .fwd_e_o         (sel),
      .fwd_d_o         (forwardD[gi]),
      .id_ex_hit_o     (id_ex_hit[gi]),
      .id_mem_hit_o    (id_mem_hit[gi])
    );

    assign forwardE[2*gi +: 2] = sel;
  end

  assign lu_haz = exMemRead && exRegWrite && (|id_ex_hit);
  assign br_haz = idBranch && ((exRegWrite && (|id_ex_hit)) ||
                               (MEMmemRead && (|id_mem_hit)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // In STALL the offending load has already moved on, so a fresh luHaz
  // cannot be the same hazard and is not re-armed here.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      HZ_RUN: begin
        if (lu_haz && (LOAD_USE_CYCLES > 1)) begin
          state_d = HZ_STALL;
          rem_d   = REM_INIT;
        end
      end
      HZ_STALL: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d = HZ_RUN;
        end
      end
      default: begin
        state_d = HZ_RUN;
        rem_d   = '0;
      end
    endcase
  end

  assign stall  = (lu_haz || br_haz || (state_q == HZ_STALL)) && !rst;
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stallCount = cnt_q;
`else
  assign stallCount = '0;
`endif

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the MIPS EX-stage forwarding logic.
- Generates EX-stage forward selects for NUM_SRC operands and ID-stage branch-compare forward selects.
- Detects load-use and branch hazards; drives stall/flush through a multi-cycle stall FSM for slow-memory loads.
- Sits beside the 5-stage pipeline registers; combinational selects, registered stall sequencing.

Parameters:
- ADDR_W, 5: register-address width.
- NUM_SRC, 2: source operands per instruction (channel 0 = Rs, 1 = Rt).
- LOAD_USE_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- idSrc  in  NUM_SRC*ADDR_W  ID source regs; channel i at [i*ADDR_W +: ADDR_W].
- idBranch  in  1  ID instruction is a branch comparing its sources.
- exSrc  in  NUM_SRC*ADDR_W  EX source regs.
- exRegWrite  in  1  EX instruction writes the RF.
- exMemRead  in  1  EX instruction is a load.
- exWriteReg  in  ADDR_W  EX destination.
- MEMregWrite  in  1  MEM instruction writes the RF.
- MEMmemRead  in  1  MEM instruction is a load.
- MEMwriteReg  in  ADDR_W  MEM destination.
- WBregWrite  in  1  WB instruction writes the RF.
- WBwriteReg  in  ADDR_W  WB destination.
- forwardE  out  2*NUM_SRC  per-channel EX select at [2i+1:2i]: 00 RF, 01 WB, 10 MEM.
- forwardD  out  NUM_SRC  per-channel ID branch-compare select, 1 = from MEM.
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID.
- flushE  out  1  bubble into ID/EX.
- stallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Register 0 never matches any hazard or forward check.
- forwardE[i]:
  - 10 if MEMregWrite and MEMwriteReg == exSrc[i].
  - else 01 if WBregWrite and WBwriteReg == exSrc[i].
  - else 00.
  - MEM has priority over WB.
  - Purely combinational, zero latency, unaffected by rst or stall state.
- forwardD[i]: 1 iff MEMregWrite, not MEMmemRead, and MEMwriteReg == idSrc[i]. Combinational.
- luHaz (load-use hazard): exMemRead and exRegWrite and exWriteReg == any idSrc[i].
- brHaz (branch hazard): idBranch and either
  - exRegWrite and exWriteReg == any idSrc[i], or
  - MEMmemRead and MEMwriteReg == any idSrc[i].
- FSM states: RUN, STALL; 4-bit remaining counter rem.
  - RUN: if luHaz and LOAD_USE_CYCLES > 1, next state STALL with rem = LOAD_USE_CYCLES-1; otherwise stay in RUN.
  - STALL: rem decrements each cycle; when rem == 1, next state is RUN.
  - STALL ignores new luHaz (the load has already left EX). brHaz is still OR-ed into the outputs.
- Stall outputs: stallF = stallD = flushE = (luHaz | brHaz | state==STALL) & ~rst.
- Resulting stall length: a load-use hazard produces exactly LOAD_USE_CYCLES consecutive stall cycles, plus any additional brHaz cycles.
- Reset: rst high sets state RUN, rem 0, stallCount 0, and forces stall outputs to 0 in the same cycle. Reset mid-STALL aborts the sequence.
- stallCount:
  - Increments on every clock edge where stallF is 1.
  - Saturates at all-ones; no wrap.
  - Reset value 0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stallCount is implemented as described above.
- Undefined: no counter flops; stallCount is tied to 0.

Decomposition:
- Shared package mips_hazard_pkg:
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - hz_state_e enum (HZ_RUN, HZ_STALL).
  - Constant ZERO_REG = '0.
- Natural sub-module: fwd_match, one per channel, generated NUM_SRC times. It computes the EX select and ID select for a single source address.
- The FSM and counter stay in the top module.

Test Plan:
- Forward priority: exSrc ch0 = 5, MEMregWrite=1/MEMwriteReg=5, WBregWrite=1/WBwriteReg=5 → forwardE[1:0]=10. Drop MEMregWrite → 01. WBwriteReg=6 → 00.
- Zero register: exSrc ch1 = 0, MEMregWrite=1, MEMwriteReg=0 → forwardE[3:2]=00, no stall.
- Load-use, LOAD_USE_CYCLES=1: exMemRead=1, exWriteReg=8, idSrc ch1 = 8 → stallF/stallD/flushE high exactly 1 cycle; stallCount 0→1.
- Load-use, LOAD_USE_CYCLES=3: same stimulus for one cycle, then hazard inputs cleared → stall high exactly 3 consecutive cycles, FSM returns to RUN, stallCount=3.
- Branch hazard and forwardD:
  - idBranch=1, exRegWrite=1, exWriteReg=9, idSrc ch0 = 9 → stall 1 cycle.
  - Next cycle MEMregWrite=1, MEMwriteReg=9, MEMmemRead=0 → forwardD[0]=1, no stall.
- Reset mid-STALL and saturation: assert rst in the 2nd stall cycle of LOAD_USE_CYCLES=3 → outputs 0 that cycle, RUN next, stallCount=0. With CNT_W=2, five stall cycles → stallCount holds 3.
